aurora_gen_msg: RTL and testbench
=================================

Name: aurora_gen_msg

Overview:
- Multi-channel Aurora status/event message generator; successor to the single-event end-of-scan acknowledge generator.
- Each of CH_NUM event sources latches a pending request plus a 32-bit payload.
- A round-robin arbiter serialises pending requests into 2-beat AXI4-Stream frames (header beat, payload beat with tlast) toward the Aurora TX user interface.
- Provides per-block frame and drop counters for register readback.

Parameters:
DATA_WD, 64, stream data width in bits; multiple of 8, minimum 64
CH_NUM, 4, number of event channels; 1 to 16
HEAD_CODE, 16'h55AA, header marker placed in beat 0
CMD_BASE, 16'h0001, command code for channel 0; channel n uses CMD_BASE+n

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_rst  input  1  synchronous clear of counters and un-granted pending requests
evt_pulse  input  CH_NUM  per-channel single-cycle event strobe
evt_data  input  CH_NUM*32  per-channel payload; channel n occupies bits [32n+31:32n], sampled with evt_pulse[n]
m_axis_tdata  output  DATA_WD  stream data
m_axis_tkeep  output  DATA_WD/8  constant all ones
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tlast  output  1  asserted on payload beat only
msg_cnt  output  32  completed frames (handshake with tlast), wraps
drop_cnt  output  32  events discarded because the channel was already pending, wraps

Behaviour:
- Reset values: tvalid, tlast, tdata, msg_cnt, drop_cnt, pending bits, payload latches all 0. FSM state is IDLE. RR pointer is 0, so channel 0 has highest priority first.
- Pending latch, per channel n:
  - evt_pulse[n] with pend[n]=0: set pend[n] and capture evt_data[n].
  - evt_pulse[n] with pend[n]=1 and not being granted this cycle: payload is unchanged and drop_cnt increments by 1. Multiple channels dropping in the same cycle add the number of dropping channels.
  - evt_pulse[n] in the same cycle pend[n] is granted: the new event is latched as a fresh pending with new data. This is not a drop.
- Arbiter: in IDLE with any pend set, grant the first set bit searching from RR pointer upward with wrap. On grant:
  - clear pend[g];
  - set RR pointer to (g+1) mod CH_NUM;
  - load beat 0 and go to HDR.
- Beat 0 tdata = {zeros, HEAD_CODE, CMD_BASE+g} (bits [31:16] header, [15:0] command). Upper bits are 0. tvalid=1, tlast=0.
- HDR: on tvalid&&tready, load beat 1 and go to PLD.
- Beat 1 tdata = {zeros, payload_g[31:0]}, tlast=1.
- PLD: on tvalid&&tready, clear tvalid, tlast and tdata, increment msg_cnt, go to IDLE.
- Latency:
  - event pulse to pend set: 1 clk;
  - pend set to tvalid high: 1 clk;
  - minimum 1 idle cycle between frames (tvalid low for at least 1 clk after tlast handshake).
  - Back-to-back throughput is 2 beats per 3 clk.
- AXIS rules:
  - tdata, tlast and tvalid hold stable while tvalid&&!tready.
  - tvalid never drops without a handshake.
  - No dependence of tvalid on tready.
- cfg_rst:
  - clears msg_cnt, drop_cnt, all pend bits and the RR pointer (to 0).
  - A frame already in HDR/PLD completes normally but is counted from 0 afterward: a completion in the cfg_rst cycle is not counted (clear wins).
  - Events arriving in the cfg_rst cycle are discarded.
- Async reset mid-frame: outputs go to 0 immediately and the frame is abandoned. The downstream Aurora reset domain owns recovery.

Test Plan:
- Single evt_pulse[2] with data 0xDEADBEEF, tready=1 → beats 0x0000_0000_55AA_0003 and 0x0000_0000_DEAD_BEEF (tlast=1); msg_cnt=1; pend cleared.
- evt_pulse=4'b1111 in one cycle with distinct data, tready=1 → frames emitted in order ch0,ch1,ch2,ch3; msg_cnt=4; drop_cnt=0; 1-cycle gap between frames.
- Hold tready=0 for 10 clk during beat 0, then during beat 1 → tdata, tlast and tvalid stable throughout; exactly 2 handshakes per frame.
- Three pulses on ch1 while its first frame is still pending (tready=0) → drop_cnt=2; emitted payload equals the first captured data.
- Pulse on ch0 in the exact grant cycle of ch0 → two ch0 frames sent; second carries the new data; drop_cnt=0.
- Assert cfg_rst during PLD with tready low, then release tready → frame completes; msg_cnt=0 after completion; pending ch3 request is cleared and never sent.

Source files
------------

// File: rtl/aurora_gen_msg.sv
// aurora_gen_msg
// Multi-channel Aurora status/event message generator. Each event channel
// latches a pending request with a 32-bit payload. A round-robin arbiter
// turns pending requests into 2-beat AXI4-Stream frames:
//   beat 0: {zeros, HEAD_CODE, CMD_BASE+ch}        tlast=0
//   beat 1: {zeros, payload[31:0]}                 tlast=1
// Completed frames and discarded (already pending) events are counted.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   cfg_rst         synchronous clear of counters, pending requests, RR pointer
//   evt_pulse       per-channel single-cycle event strobe
//   evt_data        per-channel payload, channel n at [32n+31:32n]
//   m_axis_*        AXI4-Stream master toward the Aurora TX user interface
//   msg_cnt         completed frames (tlast handshakes), wraps
//   drop_cnt        events discarded because the channel was still pending
module aurora_gen_msg #(
  parameter int          DATA_WD   = 64,
  parameter int          CH_NUM    = 4,
  parameter logic [15:0] HEAD_CODE = 16'h55AA,
  parameter logic [15:0] CMD_BASE  = 16'h0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_rst,
  input  logic [CH_NUM-1:0]      evt_pulse,
  input  logic [CH_NUM*32-1:0]   evt_data,
  output logic [DATA_WD-1:0]     m_axis_tdata,
  output logic [DATA_WD/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [31:0]            msg_cnt,
  output logic [31:0]            drop_cnt
);

  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PLD  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CH_NUM-1:0]  pend;
  logic [31:0]        payload [CH_NUM];
  logic [PTR_W-1:0]   rr_ptr;
  logic [31:0]        pld_reg;

  logic               gnt_valid;
  logic [PTR_W-1:0]   gnt_idx;
  logic               grant;
  logic [CH_NUM-1:0]  gnt_vec;
  logic [CH_NUM-1:0]  drop_vec;
  logic [31:0]        drop_num;
  logic               handshake;
  logic               frame_done;
  int                 arb_idx;

  logic [DATA_WD-1:0] tdata_nxt;
  logic               tvalid_nxt;
  logic               tlast_nxt;

  assign m_axis_tkeep = '1;
  assign handshake    = m_axis_tvalid && m_axis_tready;

  // Round-robin search: scan offsets from the highest down so the last hit,
  // which wins, is the set bit closest to rr_ptr going upward with wrap.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    arb_idx   = 0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      arb_idx = (int'(rr_ptr) + i) % CH_NUM;
      if (pend[arb_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = arb_idx[PTR_W-1:0];
      end
    end
  end

  // A grant is suppressed while cfg_rst clears the pending set.
  assign grant = (state == IDLE) && gnt_valid && !cfg_rst;

  // A pulse on a channel being granted this cycle is a fresh request, not a
  // drop; events during cfg_rst are discarded without counting.
  always_comb begin
    gnt_vec  = '0;
    drop_vec = '0;
    drop_num = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      gnt_vec[n]  = grant && (gnt_idx == PTR_W'(n));
      drop_vec[n] = evt_pulse[n] && pend[n] && !gnt_vec[n] && !cfg_rst;
      drop_num    = drop_num + {31'd0, drop_vec[n]};
    end
  end

  // Frame FSM next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    tdata_nxt  = m_axis_tdata;
    tvalid_nxt = m_axis_tvalid;
    tlast_nxt  = m_axis_tlast;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt       = HDR;
          tvalid_nxt      = 1'b1;
          tlast_nxt       = 1'b0;
          tdata_nxt       = '0;
          tdata_nxt[31:0] = {HEAD_CODE, CMD_BASE + 16'(gnt_idx)};
        end
      end
      HDR: begin
        if (handshake) begin
          state_nxt       = PLD;
          tlast_nxt       = 1'b1;
          tdata_nxt       = '0;
          tdata_nxt[31:0] = pld_reg;
        end
      end
      PLD: begin
        if (handshake) begin
          state_nxt  = IDLE;
          tvalid_nxt = 1'b0;
          tlast_nxt  = 1'b0;
          tdata_nxt  = '0;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        tvalid_nxt = 1'b0;
        tlast_nxt  = 1'b0;
        tdata_nxt  = '0;
      end
    endcase
  end

  // FSM state and registered stream outputs. The granted payload is copied
  // into pld_reg at grant time because the channel latch may be refilled by
  // a new event in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pld_reg       <= '0;
      rr_ptr        <= '0;
    end else begin
      state         <= state_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
      if (grant) begin
        pld_reg <= payload[gnt_idx];
      end
      if (cfg_rst) begin
        rr_ptr <= '0;
      end else if (grant) begin
        rr_ptr <= (gnt_idx == PTR_W'(CH_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // Per-channel pending flags and payload latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int n = 0; n < CH_NUM; n++) begin
        payload[n] <= '0;
      end
    end else if (cfg_rst) begin
      pend <= '0;
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (evt_pulse[n] && (!pend[n] || gnt_vec[n])) begin
          pend[n]    <= 1'b1;
          payload[n] <= evt_data[32*n +: 32];
        end else if (gnt_vec[n]) begin
          pend[n] <= 1'b0;
        end
      end
    end
  end

  // Frame and drop counters; cfg_rst wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt  <= '0;
      drop_cnt <= '0;
    end else if (cfg_rst) begin
      msg_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (frame_done) begin
        msg_cnt <= msg_cnt + 32'd1;
      end
      drop_cnt <= drop_cnt + drop_num;
    end
  end

endmodule

// File: tb/tb_aurora_gen_msg.sv
// tb_aurora_gen_msg
// Self-checking bench for aurora_gen_msg (default parameters: 64-bit data,
// 4 channels). Inputs change 1 time unit after the rising edge; the beat
// monitor samples on the falling edge.
module tb_aurora_gen_msg;

  logic         clk;
  logic         rst_n;
  logic         cfg_rst;
  logic [3:0]   evt_pulse;
  logic [127:0] evt_data;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [31:0]  msg_cnt;
  logic [31:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          cyc;
  } beat_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
    logic [63:0] exp_hdr;
    logic [63:0] exp_pld;
  } vec_t;

  beat_t beats[$];
  vec_t  vecs [4];

  aurora_gen_msg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_rst       (cfg_rst),
    .evt_pulse     (evt_pulse),
    .evt_data      (evt_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .msg_cnt       (msg_cnt),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every stream handshake with the falling-edge index it was seen on.
  always @(negedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      beats.push_back('{m_axis_tdata, m_axis_tlast, cyc_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBeat(input string name, input int idx,
                           input logic [63:0] exp_data, input logic exp_last);
    if (idx >= beats.size()) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: beat %0d missing, only %0d beats seen", name, idx, beats.size());
    end else begin
      checkOutput(name, beats[idx].data, exp_data);
      checkOutput({name, "_last"}, 64'(beats[idx].last), 64'(exp_last));
    end
  endtask

  function automatic logic [127:0] chData(input int ch, input logic [31:0] d);
    logic [127:0] v;
    v = '0;
    v[32*ch +: 32] = d;
    return v;
  endfunction

  // Drives one cycle of event strobes, then drops the strobes.
  task automatic applyStimulus(input logic [3:0] pulse, input logic [127:0] data);
    evt_pulse = pulse;
    evt_data  = data;
    tick();
    evt_pulse = '0;
  endtask

  task automatic waitValid(input int budget, input string name);
    int n;
    n = 0;
    while (!m_axis_tvalid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!m_axis_tvalid) begin
      errors++;
      $display("[TB] FAIL %s: tvalid still %0b after %0d cycles, expected 1", name, m_axis_tvalid, budget);
    end
  endtask

  task automatic waitBeats(input int count, input int budget, input string name);
    int n;
    n = 0;
    while (beats.size() < count && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (beats.size() < count) begin
      errors++;
      $display("[TB] FAIL %s: got %0d beats, expected %0d", name, beats.size(), count);
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [15:0]  cmd;

    vecs[0] = '{2, 32'hDEAD_BEEF, 64'h0000_0000_55AA_0003, 64'h0000_0000_DEAD_BEEF};
    vecs[1] = '{0, 32'h1234_5678, 64'h0000_0000_55AA_0001, 64'h0000_0000_1234_5678};
    vecs[2] = '{1, 32'h0000_0000, 64'h0000_0000_55AA_0002, 64'h0000_0000_0000_0000};
    vecs[3] = '{3, 32'hA5A5_5A5A, 64'h0000_0000_55AA_0004, 64'h0000_0000_A5A5_5A5A};

    rst_n         = 1'b0;
    cfg_rst       = 1'b0;
    evt_pulse     = '0;
    evt_data      = '0;
    m_axis_tready = 1'b0;
    tick();
    tick();

    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("rst_tlast",  64'(m_axis_tlast),  64'd0);
    checkOutput("rst_tdata",  m_axis_tdata,       64'd0);
    checkOutput("rst_tkeep",  64'(m_axis_tkeep),  64'hFF);
    checkOutput("rst_msg",    64'(msg_cnt),       64'd0);
    checkOutput("rst_drop",   64'(drop_cnt),      64'd0);

    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    tick();

    // Single-channel frames with ready held high; exact cycle-by-cycle timing.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'(1 << vecs[i].ch), chData(vecs[i].ch, vecs[i].data));
      checkOutput("tbl_pend_lat", 64'(m_axis_tvalid), 64'd0);
      tick();
      checkOutput("tbl_hdr_valid", 64'(m_axis_tvalid), 64'd1);
      checkOutput("tbl_hdr", m_axis_tdata, vecs[i].exp_hdr);
      checkOutput("tbl_hdr_last", 64'(m_axis_tlast), 64'd0);
      tick();
      checkOutput("tbl_pld", m_axis_tdata, vecs[i].exp_pld);
      checkOutput("tbl_pld_last", 64'(m_axis_tlast), 64'd1);
      tick();
      checkOutput("tbl_idle", 64'(m_axis_tvalid), 64'd0);
      checkOutput("tbl_msg", 64'(msg_cnt), 64'(i + 1));
    end
    checkOutput("tbl_drop", 64'(drop_cnt), 64'd0);

    // All four channels at once: round-robin order 0..3, one idle cycle between frames.
    tick();
    beats.delete();
    d = '0;
    for (int c = 0; c < 4; c++) d[32*c +: 32] = 32'hA000_0000 + 32'(c);
    applyStimulus(4'b1111, d);
    waitBeats(8, 40, "rr_beats");
    for (int k = 0; k < 4; k++) begin
      cmd = 16'h0001 + 16'(k);
      checkBeat("rr_hdr", 2*k,     {32'h0, 16'h55AA, cmd}, 1'b0);
      checkBeat("rr_pld", 2*k + 1, {32'h0, 32'hA000_0000 + 32'(k)}, 1'b1);
      if (k < 3 && beats.size() >= 8) begin
        checkOutput("rr_gap", 64'(beats[2*k+2].cyc - beats[2*k+1].cyc), 64'd2);
      end
    end
    checkOutput("rr_msg", 64'(msg_cnt), 64'd8);
    checkOutput("rr_drop", 64'(drop_cnt), 64'd0);

    // Back-pressure on both beats: outputs hold, exactly two handshakes.
    tick();
    m_axis_tready = 1'b0;
    beats.delete();
    applyStimulus(4'b0010, chData(1, 32'h0BAD_F00D));
    waitValid(10, "stall_valid");
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_hdr", m_axis_tdata, 64'h0000_0000_55AA_0002);
      checkOutput("stall_hdr_ctl", {62'd0, m_axis_tvalid, m_axis_tlast}, 64'b10);
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_pld", m_axis_tdata, 64'h0000_0000_0BAD_F00D);
      checkOutput("stall_pld_ctl", {62'd0, m_axis_tvalid, m_axis_tlast}, 64'b11);
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    checkOutput("stall_idle", 64'(m_axis_tvalid), 64'd0);
    checkOutput("stall_hs", 64'(beats.size()), 64'd2);
    checkOutput("stall_msg", 64'(msg_cnt), 64'd9);

    // Repeated pulses on a channel that is still pending are dropped.
    tick();
    m_axis_tready = 1'b0;
    beats.delete();
    applyStimulus(4'b0001, chData(0, 32'h0000_1111));
    tick();
    applyStimulus(4'b0010, chData(1, 32'h2222_0001));
    applyStimulus(4'b0010, chData(1, 32'h2222_0002));
    applyStimulus(4'b0010, chData(1, 32'h2222_0003));
    checkOutput("drop_cnt", 64'(drop_cnt), 64'd2);
    m_axis_tready = 1'b1;
    waitBeats(4, 20, "drop_beats");
    checkBeat("drop_hdr0", 0, 64'h0000_0000_55AA_0001, 1'b0);
    checkBeat("drop_pld0", 1, 64'h0000_0000_0000_1111, 1'b1);
    checkBeat("drop_hdr1", 2, 64'h0000_0000_55AA_0002, 1'b0);
    checkBeat("drop_pld1", 3, 64'h0000_0000_2222_0001, 1'b1);
    checkOutput("drop_msg", 64'(msg_cnt), 64'd11);

    // Pulse on ch0 in the very cycle ch0 is granted: re-latched, not dropped.
    tick();
    tick();
    beats.delete();
    applyStimulus(4'b0001, chData(0, 32'h3333_0001));
    applyStimulus(4'b0001, chData(0, 32'h3333_0002));
    waitBeats(4, 20, "gnt_beats");
    checkBeat("gnt_hdr0", 0, 64'h0000_0000_55AA_0001, 1'b0);
    checkBeat("gnt_pld0", 1, 64'h0000_0000_3333_0001, 1'b1);
    checkBeat("gnt_hdr1", 2, 64'h0000_0000_55AA_0001, 1'b0);
    checkBeat("gnt_pld1", 3, 64'h0000_0000_3333_0002, 1'b1);
    checkOutput("gnt_drop", 64'(drop_cnt), 64'd2);
    checkOutput("gnt_msg", 64'(msg_cnt), 64'd13);

    // cfg_rst during a stalled payload beat with ch3 pending.
    tick();
    m_axis_tready = 1'b0;
    applyStimulus(4'b0100, chData(2, 32'hCAFE_0002));
    waitValid(10, "cfg_valid");
    m_axis_tready = 1'b1;
    applyStimulus(4'b1000, chData(3, 32'h4444_4444));
    m_axis_tready = 1'b0;
    cfg_rst = 1'b1;
    applyStimulus(4'b0001, chData(0, 32'h5555_5555));
    checkOutput("cfg_msg_clr", 64'(msg_cnt), 64'd0);
    checkOutput("cfg_drop_clr", 64'(drop_cnt), 64'd0);
    checkOutput("cfg_pld_hold", m_axis_tdata, 64'h0000_0000_CAFE_0002);
    checkOutput("cfg_pld_ctl", {62'd0, m_axis_tvalid, m_axis_tlast}, 64'b11);
    m_axis_tready = 1'b1;
    tick();
    cfg_rst = 1'b0;
    checkOutput("cfg_done_idle", 64'(m_axis_tvalid), 64'd0);
    checkOutput("cfg_done_msg", 64'(msg_cnt), 64'd0);
    beats.delete();
    for (int i = 0; i < 10; i++) tick();
    checkOutput("cfg_no_frames", 64'(beats.size()), 64'd0);
    checkOutput("cfg_msg_after", 64'(msg_cnt), 64'd0);

    // Counting restarts from zero after cfg_rst.
    beats.delete();
    applyStimulus(4'b0010, chData(1, 32'h6666_6666));
    waitBeats(2, 10, "post_beats");
    checkBeat("post_pld", 1, 64'h0000_0000_6666_6666, 1'b1);
    checkOutput("post_msg", 64'(msg_cnt), 64'd1);

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    tick();
    m_axis_tready = 1'b0;
    applyStimulus(4'b0001, chData(0, 32'h7777_7777));
    waitValid(10, "arst_valid");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("arst_tdata", m_axis_tdata, 64'd0);
    checkOutput("arst_msg", 64'(msg_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("arst_after", 64'(m_axis_tvalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
